// File: rtl/vscale_hasti_sram.sv
// vscale_hasti_sram: point-to-point HASTI (AHB-Lite) slave SRAM with wait states and ERROR response.
// Define VSCALE_SRAM_STATS_EN to add stat_reads/stat_writes/stat_errors completion counters.
`ifndef HASTI_ADDR_WIDTH
`define HASTI_ADDR_WIDTH 32
`endif
`ifndef HASTI_BUS_WIDTH
`define HASTI_BUS_WIDTH 32
`endif
`ifndef HASTI_SIZE_WIDTH
`define HASTI_SIZE_WIDTH 3
`endif
`ifndef HASTI_BURST_WIDTH
`define HASTI_BURST_WIDTH 3
`endif
`ifndef HASTI_PROT_WIDTH
`define HASTI_PROT_WIDTH 4
`endif
`ifndef HASTI_TRANS_WIDTH
`define HASTI_TRANS_WIDTH 2
`endif
`ifndef HASTI_RESP_WIDTH
`define HASTI_RESP_WIDTH 1
`endif

module vscale_hasti_sram #(
  parameter int unsigned NWORDS      = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [`HASTI_ADDR_WIDTH-1:0]   haddr,
  input  logic                           hwrite,
  input  logic [`HASTI_SIZE_WIDTH-1:0]   hsize,
  input  logic [`HASTI_BURST_WIDTH-1:0]  hburst,
  input  logic                           hmastlock,
  input  logic [`HASTI_PROT_WIDTH-1:0]   hprot,
  input  logic [`HASTI_TRANS_WIDTH-1:0]  htrans,
  input  logic [`HASTI_BUS_WIDTH-1:0]    hwdata,
  output logic [`HASTI_BUS_WIDTH-1:0]    hrdata,
  output logic                           hready,
  output logic [`HASTI_RESP_WIDTH-1:0]   hresp
`ifdef VSCALE_SRAM_STATS_EN
  ,
  output logic [31:0]                    stat_reads,
  output logic [31:0]                    stat_writes,
  output logic [31:0]                    stat_errors
`endif
);

  localparam int unsigned IW        = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [31:0] NWORDS_W  = 32'(NWORDS);
  localparam logic [3:0]  WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t        state;
  logic [IW-1:0] idx_q;
  logic [1:0]    lane_q;
  logic          wr_q;
  logic [2:0]    size_q;
  logic [3:0]    cnt;
  logic [3:0]    wmask;
  logic [31:0]   mem [NWORDS];

  logic [31:0] offset;
  logic        size_ok, align_ok, range_ok, legal;
  logic        unused_ok;

  // Wrap-around of the subtract is caught by the explicit haddr >= BASE_ADDR test.
  always_comb begin
    offset   = haddr - BASE_ADDR;
    size_ok  = (hsize <= 3'd2);
    align_ok = (hsize == 3'd0) ||
               ((hsize == 3'd1) && !haddr[0]) ||
               ((hsize == 3'd2) && (haddr[1:0] == 2'b00));
    range_ok = (haddr >= BASE_ADDR) && ({2'b00, offset[31:2]} < NWORDS_W);
    legal    = size_ok && align_ok && range_ok;
  end

  assign unused_ok = ^{hburst, hmastlock, hprot, htrans[0], offset[1:0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      hready <= 1'b1;
      hresp  <= '0;
      cnt    <= '0;
      idx_q  <= '0;
      lane_q <= '0;
      wr_q   <= 1'b0;
      size_q <= '0;
    end else begin
      case (state)
        S_WAIT: begin
          if (cnt == '0) begin
            state  <= S_DATA;
            hready <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_ERR1: begin
          state  <= S_ERR2;
          hready <= 1'b1;
          hresp  <= 1'b1;
        end
        default: begin
          if (htrans[1]) begin
            idx_q  <= offset[IW+1:2];
            lane_q <= haddr[1:0];
            wr_q   <= hwrite;
            size_q <= hsize;
            if (!legal) begin
              state  <= S_ERR1;
              hready <= 1'b0;
              hresp  <= 1'b1;
            end else if (WAIT_CYCLES == 0) begin
              state  <= S_DATA;
              hready <= 1'b1;
              hresp  <= 1'b0;
            end else begin
              state  <= S_WAIT;
              cnt    <= WAIT_INIT;
              hready <= 1'b0;
              hresp  <= 1'b0;
            end
          end else begin
            state  <= S_IDLE;
            hready <= 1'b1;
            hresp  <= 1'b0;
          end
        end
      endcase
    end
  end

  always_comb begin
    wmask = '0;
    case (size_q)
      3'd0:    wmask[lane_q] = 1'b1;
      3'd1:    wmask = lane_q[1] ? 4'b1100 : 4'b0011;
      default: wmask = '1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_DATA && wr_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (wmask[b]) mem[idx_q][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  assign hrdata = (state == S_DATA && !wr_q) ? mem[idx_q] : '0;

`ifdef VSCALE_SRAM_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_reads  <= '0;
      stat_writes <= '0;
      stat_errors <= '0;
    end else begin
      if (state == S_DATA) begin
        if (wr_q) stat_writes <= stat_writes + 32'd1;
        else      stat_reads  <= stat_reads + 32'd1;
      end
      if (state == S_ERR2) stat_errors <= stat_errors + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vscale_hasti_sram.sv
// Bench for vscale_hasti_sram: three instances (0/3/2 wait states), byte-addressed reference model,
// directed plan scenarios plus randomized pipelined traffic.
module tb_vscale_hasti_sram;

  localparam int NW = 64;

  typedef struct {
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        write;
    logic [2:0]  size;
    logic [31:0] wdata;
  } op_t;

  logic        clk;
  logic        reset_n;
  logic [31:0] haddr  [3];
  logic        hwrite [3];
  logic [2:0]  hsize  [3];
  logic [2:0]  hburst [3];
  logic        hmastlock [3];
  logic [3:0]  hprot  [3];
  logic [1:0]  htrans [3];
  logic [31:0] hwdata [3];
  logic [31:0] hrdata [3];
  logic        hready [3];
  logic        hresp  [3];
`ifdef VSCALE_SRAM_STATS_EN
  logic [31:0] st_rd [3];
  logic [31:0] st_wr [3];
  logic [31:0] st_er [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    vscale_hasti_sram #(
      .NWORDS      (NW),
      .BASE_ADDR   ((g == 2) ? 32'h8000_0000 : 32'h0000_0000),
      .WAIT_CYCLES ((g == 0) ? 0 : ((g == 1) ? 3 : 2))
    ) u_dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .haddr     (haddr[g]),
      .hwrite    (hwrite[g]),
      .hsize     (hsize[g]),
      .hburst    (hburst[g]),
      .hmastlock (hmastlock[g]),
      .hprot     (hprot[g]),
      .htrans    (htrans[g]),
      .hwdata    (hwdata[g]),
      .hrdata    (hrdata[g]),
      .hready    (hready[g]),
      .hresp     (hresp[g])
`ifdef VSCALE_SRAM_STATS_EN
      ,
      .stat_reads  (st_rd[g]),
      .stat_writes (st_wr[g]),
      .stat_errors (st_er[g])
`endif
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mmem [3][NW*4];
  int          cnt_rd [3];
  int          cnt_wr [3];
  int          cnt_er [3];
  logic [31:0] last_rdata;
  op_t         ops [$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] base_of(input int s);
    return (s == 2) ? 32'h8000_0000 : 32'h0000_0000;
  endfunction

  function automatic int wait_of(input int s);
    return (s == 0) ? 0 : ((s == 1) ? 3 : 2);
  endfunction

  function automatic op_t mk(input logic [1:0] trans, input logic [31:0] addr, input logic write,
                             input logic [2:0] size, input logic [31:0] wdata);
    op_t o;
    o.trans = trans; o.addr = addr; o.write = write; o.size = size; o.wdata = wdata;
    return o;
  endfunction

  function automatic bit legal_op(input int s, input op_t o);
    logic [31:0] off;
    off = o.addr - base_of(s);
    if (o.size > 3'd2) return 1'b0;
    if ((o.addr & ((32'd1 << o.size) - 32'd1)) != 32'd0) return 1'b0;
    if (o.addr < base_of(s)) return 1'b0;
    return (off / 32'd4) < 32'(NW);
  endfunction

  function automatic logic [31:0] model_word(input int s, input logic [31:0] addr);
    int unsigned o;
    o = (addr - base_of(s)) & ~32'd3;
    return {mmem[s][o+3], mmem[s][o+2], mmem[s][o+1], mmem[s][o]};
  endfunction

  task automatic model_write(input int s, input op_t o);
    int unsigned a;
    int unsigned lane;
    for (int b = 0; b < (1 << o.size); b++) begin
      a    = o.addr - base_of(s) + 32'(b);
      lane = (o.addr + 32'(b)) % 4;
      mmem[s][a] = o.wdata[8*lane +: 8];
    end
  endtask

  task automatic drive(input int s, input op_t o);
    haddr[s]     = o.addr;
    hwrite[s]    = o.write;
    hsize[s]     = o.size;
    htrans[s]    = o.trans;
    hburst[s]    = 3'($urandom);
    hprot[s]     = 4'($urandom);
    hmastlock[s] = 1'($urandom);
  endtask

  // Pipelined master: one address phase overlaps the previous transfer's data phase.
  task automatic run_ops(input int s);
    op_t         cur, prev;
    bit          have_prev, ok, exp_rdy, exp_rsp;
    int          k, i, w;
    logic [31:0] exp_rdata;
    have_prev = 0; k = 0; i = 0; ok = 0;
    w = wait_of(s);
    prev = mk(2'd0, 32'd0, 1'b0, 3'd0, 32'd0);
    while (i < ops.size() || have_prev) begin
      cur = (i < ops.size()) ? ops[i] : mk(2'd0, 32'd0, 1'b0, 3'd0, 32'd0);
      drive(s, cur);
      hwdata[s] = have_prev ? prev.wdata : $urandom;
      @(negedge clk);
      exp_rdy = 1; exp_rsp = 0; exp_rdata = '0;
      if (have_prev) begin
        ok = legal_op(s, prev);
        if (ok) begin
          exp_rdy = (k == w);
          if (exp_rdy && !prev.write) exp_rdata = model_word(s, prev.addr);
        end else begin
          exp_rdy = (k == 1);
          exp_rsp = 1;
        end
      end
      check($sformatf("hready[%0d]", s), 32'(hready[s]), 32'(exp_rdy));
      check($sformatf("hresp[%0d]", s), 32'(hresp[s]), 32'(exp_rsp));
      check($sformatf("hrdata[%0d]", s), hrdata[s], exp_rdata);
      if (have_prev && exp_rdy && ok && !prev.write) last_rdata = hrdata[s];
      @(posedge clk); #1;
      if (exp_rdy) begin
        if (have_prev) begin
          if (!ok) cnt_er[s]++;
          else if (prev.write) begin model_write(s, prev); cnt_wr[s]++; end
          else cnt_rd[s]++;
        end
        have_prev = 0;
        if (i < ops.size()) begin
          if (cur.trans[1]) begin prev = cur; have_prev = 1; k = 0; end
          i++;
        end
      end else begin
        k++;
      end
    end
    ops.delete();
    drive(s, mk(2'd0, 32'd0, 1'b0, 3'd0, 32'd0));
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int s = 0; s < 3; s++) begin cnt_rd[s] = 0; cnt_wr[s] = 0; cnt_er[s] = 0; end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    op_t         o;
    logic [31:0] old;
    int          r;
    reset_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      drive(s, mk(2'd0, 32'd0, 1'b0, 3'd0, 32'd0));
      hwdata[s] = '0;
      cnt_rd[s] = 0; cnt_wr[s] = 0; cnt_er[s] = 0;
    end
    last_rdata = '0;
    #23;
    for (int s = 0; s < 3; s++) begin
      check("reset_hready", 32'(hready[s]), 32'd1);
      check("reset_hresp", 32'(hresp[s]), 32'd0);
      check("reset_hrdata", hrdata[s], 32'd0);
    end
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;

    for (int s = 0; s < 3; s++) begin
      for (int w = 0; w < NW; w++) ops.push_back(mk(2'd2, base_of(s) + 32'(4*w), 1'b1, 3'd2, $urandom));
      run_ops(s);
    end

    ops.push_back(mk(2'd2, 32'h10, 1'b1, 3'd2, 32'hDEADBEEF));
    ops.push_back(mk(2'd2, 32'h10, 1'b0, 3'd2, 32'h0));
    run_ops(0);
    check("t1_raw", last_rdata, 32'hDEADBEEF);

    ops.push_back(mk(2'd2, 32'h10, 1'b1, 3'd2, 32'h11223344));
    ops.push_back(mk(2'd3, 32'h13, 1'b1, 3'd0, 32'hAA000000));
    ops.push_back(mk(2'd2, 32'h10, 1'b0, 3'd2, 32'h0));
    run_ops(0);
    check("t2_byte", last_rdata, 32'hAA223344);
    ops.push_back(mk(2'd2, 32'h10, 1'b1, 3'd1, 32'h00005566));
    ops.push_back(mk(2'd2, 32'h10, 1'b0, 3'd2, 32'h0));
    run_ops(0);
    check("t2_half", last_rdata, 32'hAA225566);

    ops.push_back(mk(2'd2, 32'h20, 1'b0, 3'd2, 32'h0));
    ops.push_back(mk(2'd2, 32'h24, 1'b0, 3'd2, 32'h0));
    run_ops(1);
    check("t3_held", last_rdata, model_word(1, 32'h24));

    ops.push_back(mk(2'd2, 32'h01, 1'b1, 3'd1, 32'hFFFFFFFF));
    ops.push_back(mk(2'd2, 32'h00, 1'b0, 3'd2, 32'h0));
    ops.push_back(mk(2'd2, 32'(4*NW), 1'b0, 3'd2, 32'h0));
    ops.push_back(mk(2'd2, 32'h00, 1'b0, 3'd2, 32'h0));
    run_ops(0);
    check("t4_unchanged", last_rdata, model_word(0, 32'h00));
    ops.push_back(mk(2'd2, 32'h7FFF_FFFC, 1'b0, 3'd2, 32'h0));
    ops.push_back(mk(2'd0, 32'h0, 1'b0, 3'd0, 32'h0));
    ops.push_back(mk(2'd2, 32'h8000_0000, 1'b1, 3'd3, 32'h0));
    ops.push_back(mk(2'd2, 32'h8000_0000, 1'b0, 3'd2, 32'h0));
    run_ops(2);
    check("t4_unchanged2", last_rdata, model_word(2, 32'h8000_0000));

    old = model_word(2, 32'h8000_0030);
    drive(2, mk(2'd2, 32'h8000_0030, 1'b1, 3'd2, 32'h0));
    @(posedge clk); #1;
    drive(2, mk(2'd0, 32'h0, 1'b0, 3'd0, 32'h0));
    hwdata[2] = ~old;
    #2;
    check("t5_in_wait", 32'(hready[2]), 32'd0);
    reset_n = 1'b0;
    #1;
    check("t5_async_hready", 32'(hready[2]), 32'd1);
    check("t5_async_hresp", 32'(hresp[2]), 32'd0);
    check("t5_async_hrdata", hrdata[2], 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    for (int s = 0; s < 3; s++) begin cnt_rd[s] = 0; cnt_wr[s] = 0; cnt_er[s] = 0; end
    ops.push_back(mk(2'd2, 32'h8000_0030, 1'b0, 3'd2, 32'h0));
    run_ops(2);
    check("t5_old_data", last_rdata, old);

    pulse_reset();
`ifdef VSCALE_SRAM_STATS_EN
    check("t6_rst_reads", st_rd[0], 32'd0);
    check("t6_rst_writes", st_wr[0], 32'd0);
    check("t6_rst_errors", st_er[0], 32'd0);
`endif
    ops.push_back(mk(2'd2, 32'h40, 1'b1, 3'd2, 32'h01020304));
    ops.push_back(mk(2'd1, 32'h0, 1'b0, 3'd0, 32'h0));
    ops.push_back(mk(2'd2, 32'h40, 1'b0, 3'd2, 32'h0));
    ops.push_back(mk(2'd3, 32'h42, 1'b1, 3'd1, 32'hBEEF0000));
    ops.push_back(mk(2'd0, 32'h0, 1'b0, 3'd0, 32'h0));
    ops.push_back(mk(2'd2, 32'h03, 1'b0, 3'd2, 32'h0));
    ops.push_back(mk(2'd2, 32'h44, 1'b0, 3'd0, 32'h0));
    ops.push_back(mk(2'd3, 32'h46, 1'b0, 3'd1, 32'h0));
    ops.push_back(mk(2'd1, 32'h0, 1'b0, 3'd0, 32'h0));
    ops.push_back(mk(2'd2, 32'h41, 1'b1, 3'd0, 32'h00005500));
    ops.push_back(mk(2'd2, 32'h40, 1'b0, 3'd4, 32'h0));
    ops.push_back(mk(2'd2, 32'h40, 1'b0, 3'd2, 32'h0));
    ops.push_back(mk(2'd2, 32'h48, 1'b0, 3'd2, 32'h0));
    run_ops(0);
    check("t6_data", last_rdata, model_word(0, 32'h48));
`ifdef VSCALE_SRAM_STATS_EN
    check("t6_reads", st_rd[0], 32'd5);
    check("t6_writes", st_wr[0], 32'd3);
    check("t6_errors", st_er[0], 32'd2);
`endif

    for (int s = 0; s < 3; s++) begin
      for (int n = 0; n < 80; n++) begin
        r = $urandom_range(0, 9);
        o.trans = (r == 0) ? 2'd0 : ((r == 1) ? 2'd1 : 2'($urandom_range(2, 3)));
        o.write = 1'($urandom);
        o.size  = ($urandom_range(0, 19) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
        o.wdata = $urandom;
        r = $urandom_range(0, 9);
        if (r == 0)      o.addr = base_of(s) + 32'(4*NW) + (32'($urandom_range(0, 15)) & ~32'd3);
        else if (r == 1) o.addr = base_of(s) - 32'd4;
        else if (r == 2) o.addr = base_of(s) + 32'($urandom_range(0, 4*NW-1));
        else o.addr = base_of(s) + (32'($urandom_range(0, 4*NW-1)) & ~((32'd1 << o.size) - 32'd1));
        ops.push_back(o);
      end
      run_ops(s);
`ifdef VSCALE_SRAM_STATS_EN
      check("rand_reads", st_rd[s], 32'(cnt_rd[s]));
      check("rand_writes", st_wr[s], 32'(cnt_wr[s]));
      check("rand_errors", st_er[s], 32'(cnt_er[s]));
`endif
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
